mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single byte-wide RAM port between instruction fetch (IF) and the
//  MEM stage's load/store traffic. Serialises each request into byte beats and
//  reassembles read data little-endian. Returns a one-cycle done pulse to the
//  winning requester. IF/MEM hold their stage (via stall_ctrl) until done.
// PARAMETERS
//  ADDR_W   32  width of requester and RAM byte addresses
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  rdy        in   1       global ready; 0 freezes the block
//  if_req     in   1       fetch request, level, held until if_done
//  if_addr    in   ADDR_W  fetch byte address (always word fetch)
//  if_data    out  32      fetched instruction, valid with if_done
//  if_done    out  1       one-cycle fetch-complete pulse
//  mem_req    in   1       load/store request, level, held until mem_done
//  mem_we     in   1       1=store, 0=load
//  mem_len    in   2       0=byte, 1=half, 2/3=word (3 treated as word)
//  mem_addr   in   ADDR_W  load/store byte address
//  mem_wdata  in   32      store data; low bytes used for byte/half
//  mem_rdata  out  32      load data, zero-extended; MEM does sign-extension
//  mem_done   out  1       one-cycle load/store-complete pulse
//  ram_din    in   8       RAM read byte; 1-cycle read latency
//  ram_dout   out  8       RAM write byte
//  ram_addr   out  ADDR_W  RAM byte address
//  ram_wr     out  1       1=write this cycle
//  busy       out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; counters 0; all outputs 0 (if_data, mem_rdata included).
//  States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
//  N = beat count = 1/2/4 from mem_len; IF always uses N=4.
//  IDLE arbitration:
//   - mem_req beats if_req (fixed MEM priority). Latch addr/len/wdata/owner.
//   - Go to MEM_WR if mem_we, else MEM_RD; else IF_RD if if_req; else stay.
//  Read timing (acceptance edge = E0):
//   - ram_addr = base+k in cycles 1..N.
//   - Byte k is captured from ram_din at end of cycle k+1.
//   - Byte k goes to bits [8k+7:8k]; unused bytes are 0.
//   - Then DONE: done pulse in cycle N+2.
//  Write timing:
//   - In cycles 1..N: ram_wr=1, ram_addr=base+k, ram_dout=wdata[8k+7:8k].
//   - Then DONE: mem_done in cycle N+1.
//  DONE: state for exactly one cycle.
//   - Assert the owner's done pulse; the data output stays stable.
//   - Next state is IDLE; no new request is accepted in the DONE cycle.
//   - Requester drops req in the cycle it sees done.
//  Outside write beats: ram_wr=0. ram_addr=0 and ram_dout=0 in IDLE/DONE.
//  Address arithmetic: base+k wraps modulo 2^ADDR_W.
//  IF abort: if_req low during IF_RD means a flush.
//   - Next state is IDLE, with no if_done.
//   - if_data is unchanged; partial bytes are discarded.
//  MEM transfers are never aborted; mem_req drop mid-transfer is ignored.
//  rdy=0: hold state, counters and outputs; force ram_wr=0; ignore requests.
//   - The beat stalled by rdy=0 is reissued when rdy returns to 1.
//  rst mid-transfer: immediate return to reset values; no done pulse.
//   - A write may be left partially committed in RAM.
// TESTING
//  1. Word fetch: if_req, addr 0x100, RAM bytes 13,05,00,00 -> ram_addr 100..103;
//     if_data=0x00000513 with if_done in cycle 6; single pulse.
//  2. Collision: if_req and mem_req (lb @0x20, byte 0xF0) rise together ->
//     MEM served first, mem_rdata=0x000000F0; IF then starts after DONE+IDLE.
//  3. Store half: mem_we=1, len=1, addr 0xFFFFFFFF, wdata 0xAABBCCDD ->
//     DD @FFFFFFFF, CC @00000000 (wrap), ram_wr two cycles, mem_done cycle 3.
//  4. Flush: drop if_req after 2 beats -> IDLE next cycle, no if_done,
//     if_data unchanged; a following mem_req is accepted normally.
//  5. rdy low for 3 cycles mid word load -> ram_wr stays 0, no beat lost;
//     result equals the no-stall result, delayed by 3 cycles.
//  6. rst pulse during MEM_WR beat 2 -> all outputs 0 immediately;
//     no mem_done; a new request after reset is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : byte-serialising arbiter sharing one RAM port between IF and MEM
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        len_q, len_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              owner_mem_q, owner_mem_d;
    logic [2:0]        cnt_q, cnt_d;

    logic [2:0]        beats;
    logic [2:0]        idx;
    logic [4:0]        cap_sh;
    logic [31:0]       read_word;
    logic [7:0]        wr_byte;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        owner_mem_d = owner_mem_q;
        cnt_d       = cnt_q;
        ram_addr    = '0;
        ram_dout    = 8'h00;
        ram_wr      = 1'b0;
        idx         = 3'd0;

        beats     = (len_q == 2'd0) ? 3'd1 : (len_q == 2'd1) ? 3'd2 : 3'd4;
        // cnt_q counts issued addresses, so the byte arriving now is cnt_q-1
        cap_sh    = {cnt_q[1:0] - 2'd1, 3'b000};
        read_word = buf_q | (32'(ram_din) << cap_sh);
        case (cnt_q[1:0])
            2'd0:    wr_byte = wdata_q[7:0];
            2'd1:    wr_byte = wdata_q[15:8];
            2'd2:    wr_byte = wdata_q[23:16];
            default: wr_byte = wdata_q[31:24];
        endcase

        case (state_q)
            IDLE: begin
                if (rdy && mem_req) begin
                    base_d      = mem_addr;
                    len_d       = mem_len;
                    wdata_d     = mem_wdata;
                    owner_mem_d = 1'b1;
                    cnt_d       = 3'd0;
                    buf_d       = 32'h0;
                    state_d     = mem_we ? MEM_WR : MEM_RD;
                end else if (rdy && if_req) begin
                    base_d      = if_addr;
                    len_d       = 2'd2;
                    owner_mem_d = 1'b0;
                    cnt_d       = 3'd0;
                    buf_d       = 32'h0;
                    state_d     = IF_RD;
                end
            end
            IF_RD, MEM_RD: begin
                // While frozen, re-present the address whose byte is still owed
                if (rdy && cnt_q != beats) begin
                    idx = cnt_q;
                end else if (cnt_q != 3'd0) begin
                    idx = cnt_q - 3'd1;
                end
                ram_addr = base_q + ADDR_W'(idx);
                if (rdy) begin
                    if (state_q == IF_RD && !if_req) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            buf_d = read_word;
                        end
                        if (cnt_q == beats) begin
                            state_d = DONE;
                            cnt_d   = 3'd0;
                            if (state_q == IF_RD) begin
                                if_data_d = read_word;
                            end else begin
                                mem_rdata_d = read_word;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
            end
            MEM_WR: begin
                ram_addr = base_q + ADDR_W'(cnt_q);
                ram_dout = wr_byte;
                ram_wr   = rdy;
                if (rdy) begin
                    if (cnt_q == beats - 3'd1) begin
                        state_d = DONE;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            DONE: begin
                if (rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= 2'd0;
            wdata_q     <= 32'h0;
            buf_q       <= 32'h0;
            if_data_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
            owner_mem_q <= 1'b0;
            cnt_q       <= 3'd0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            owner_mem_q <= owner_mem_d;
            cnt_q       <= cnt_d;
        end
    end

    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;
    assign if_done   = (state_q == DONE) && !owner_mem_q;
    assign mem_done  = (state_q == DONE) && owner_mem_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: vector table, hand-written corner sequences and randomized
// traffic compared against a byte-addressed memory model.
module tb_mem_arbiter;
    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        rst, rdy, if_req, mem_req, mem_we;
    logic [1:0]  mem_len;
    logic [31:0] if_addr, mem_addr, mem_wdata, if_data, mem_rdata;
    logic        if_done, mem_done, ram_wr, busy;
    logic [7:0]  ram_din = 8'h00;
    logic [7:0]  ram_dout;
    logic [31:0] ram_addr;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_if_data = 32'h0;
    logic [31:0] exp_mem_rdata = 32'h0;

    logic [7:0] ram   [logic [31:0]];
    logic [7:0] model [logic [31:0]];

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_cyc;
    } vec_t;
    vec_t vecs [10];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_addr(ram_addr),
        .ram_wr(ram_wr), .busy(busy)
    );

    function automatic logic [7:0] ram_rd(logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    always @(posedge clk) if (ram_wr) ram[ram_addr] = ram_dout;
    always @(posedge clk) ram_din <= ram_rd(ram_addr);

    function automatic int beats(logic [1:0] l);
        return (l == 2'd0) ? 1 : (l == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] a, int n);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < n; k++)
            v[8*k +: 8] = model.exists(a + 32'(k)) ? model[a + 32'(k)] : 8'h00;
        return v;
    endfunction

    function automatic logic [31:0] ram_load(logic [31:0] a, int n);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ram_rd(a + 32'(k));
        return v;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] v);
        ram[a] = v;
        model[a] = v;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input string name, input bit is_mem, input bit we,
                           input logic [1:0] len, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_data,
                           input int exp_cyc, input int stall_at, input int stall_len);
        int n, cyc, act_beats;
        bit seen, bad_addr, bad_wr, bad_other;
        n = is_mem ? beats(len) : 4;
        @(negedge clk);
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        cyc = 0; act_beats = 0; seen = 0; bad_addr = 0; bad_wr = 0; bad_other = 0;
        while (!seen && cyc < 60) begin
            @(posedge clk); #1; cyc++;
            rdy = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            if (!rdy && ram_wr) bad_wr = 1;
            if (is_mem ? if_done : mem_done) bad_other = 1;
            if (is_mem ? mem_done : if_done) begin
                seen = 1;
            end else if (rdy && act_beats < n) begin
                if (ram_addr !== addr + 32'(act_beats)) bad_addr = 1;
                if (is_mem && we && (ram_wr !== 1'b1 || ram_dout !== wdata[8*act_beats +: 8]))
                    bad_wr = 1;
                act_beats++;
            end else if (ram_wr !== 1'b0) begin
                bad_wr = 1;
            end
        end
        rdy = 1'b1;
        chk({name, " done cycle"}, cyc, exp_cyc + stall_len);
        chk({name, " data"}, is_mem ? mem_rdata : if_data, exp_data);
        chk({name, " beat addresses"}, {31'h0, bad_addr}, 32'h0);
        chk({name, " write strobes"}, {31'h0, bad_wr}, 32'h0);
        chk({name, " wrong requester done"}, {31'h0, bad_other}, 32'h0);
        if (is_mem) mem_req = 1'b0; else if_req = 1'b0;
        if (is_mem && we) begin
            for (int k = 0; k < n; k++) model[addr + 32'(k)] = wdata[8*k +: 8];
            chk({name, " ram contents"}, ram_load(addr, n), model_load(addr, n));
        end else if (is_mem) begin
            exp_mem_rdata = exp_data;
        end else begin
            exp_if_data = exp_data;
        end
        @(posedge clk); #2;
        chk({name, " single pulse/idle"}, {29'h0, if_done, mem_done, busy}, 32'h0);
    endtask

    initial begin
        int cyc, mcyc, icyc;
        bit seen;
        logic [31:0] addr5;

        rst = 1'b1; rdy = 1'b1; if_req = 0; mem_req = 0; mem_we = 0; mem_len = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0;
        preload(32'h100, 8'h13); preload(32'h101, 8'h05); preload(32'h102, 8'h00);
        preload(32'h103, 8'h00); preload(32'h104, 8'h77); preload(32'hFFFF_FFFE, 8'h11);
        preload(32'h1, 8'h22); preload(32'h20, 8'hF0); preload(32'h41, 8'h9A);
        for (int i = 0; i < 256; i++) preload(32'h200 + 32'(i), 8'($urandom));

        vecs[0] = '{0, 0, 2'd0, 32'h0000_0100, 32'h0,         32'h0000_0513, 6};
        vecs[1] = '{1, 1, 2'd1, 32'hFFFF_FFFF, 32'hAABB_CCDD, 32'h0000_0000, 3};
        vecs[2] = '{1, 0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'h22CC_DD11, 6};
        vecs[3] = '{1, 0, 2'd0, 32'h0000_0020, 32'h0,         32'h0000_00F0, 3};
        vecs[4] = '{1, 0, 2'd3, 32'h0000_0100, 32'h0,         32'h0000_0513, 6};
        vecs[5] = '{1, 1, 2'd0, 32'h0000_0040, 32'h1234_5678, 32'h0000_0513, 2};
        vecs[6] = '{1, 0, 2'd1, 32'h0000_0040, 32'h0,         32'h0000_9A78, 4};
        vecs[7] = '{1, 1, 2'd2, 32'h0000_0080, 32'hDEAD_BEEF, 32'h0000_9A78, 5};
        vecs[8] = '{0, 0, 2'd0, 32'h0000_0080, 32'h0,         32'hDEAD_BEEF, 6};
        vecs[9] = '{1, 0, 2'd1, 32'h0000_0103, 32'h0,         32'h0000_7700, 4};

        repeat (3) @(posedge clk);
        #2;
        chk("reset flags", {28'h0, busy, ram_wr, if_done, mem_done}, 32'h0);
        chk("reset if_data", if_data, 32'h0);
        chk("reset mem_rdata", mem_rdata, 32'h0);
        chk("reset ram_addr/dout", {ram_addr[23:0], ram_dout}, 32'h0);
        @(negedge clk); rst = 1'b0;

        foreach (vecs[i])
            run_txn($sformatf("vec%0d", i), vecs[i].is_mem, vecs[i].we, vecs[i].len,
                    vecs[i].addr, vecs[i].wdata, vecs[i].exp_data, vecs[i].exp_cyc, 0, 0);

        // Simultaneous requests: MEM served first, IF accepted after DONE + IDLE
        @(negedge clk);
        mem_req = 1; mem_we = 0; mem_len = 2'd0; mem_addr = 32'h20;
        if_req = 1; if_addr = 32'h100;
        cyc = 0; mcyc = 0; icyc = 0; addr5 = 32'hX;
        while (icyc == 0 && cyc < 40) begin
            @(posedge clk); #1; cyc++;
            if (mem_done && mcyc == 0) begin
                mcyc = cyc;
                chk("collision mem_rdata", mem_rdata, 32'h0000_00F0);
                mem_req = 0;
            end
            if (cyc == 5) addr5 = ram_addr;
            if (if_done) begin
                icyc = cyc;
                chk("collision if_data", if_data, 32'h0000_0513);
                if_req = 0;
            end
        end
        mem_req = 0; if_req = 0;
        chk("collision mem_done cycle", mcyc, 3);
        chk("collision if_done cycle", icyc, 10);
        chk("collision IF first addr", addr5, 32'h100);
        exp_if_data = 32'h0000_0513; exp_mem_rdata = 32'h0000_00F0;
        @(posedge clk); #2;

        // Fetch flushed after two beats
        @(negedge clk); if_req = 1; if_addr = 32'h210;
        seen = 0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 3) if_req = 0;
            if (if_done) seen = 1;
        end
        chk("flush busy", {31'h0, busy}, 32'h0);
        chk("flush no if_done", {31'h0, seen}, 32'h0);
        chk("flush if_data kept", if_data, exp_if_data);
        run_txn("after flush", 1, 0, 2'd2, 32'h100, 32'h0, 32'h0000_0513, 6, 0, 0);

        run_txn("stall load", 1, 0, 2'd2, 32'h100, 32'h0, 32'h0000_0513, 6, 2, 3);
        run_txn("stall store", 1, 1, 2'd2, 32'h2F0, 32'hCAFE_F00D, exp_mem_rdata, 5, 3, 3);
        run_txn("stall readback", 1, 0, 2'd2, 32'h2F0, 32'h0, 32'hCAFE_F00D, 6, 0, 0);

        for (int t = 0; t < 40; t++) begin
            int kind, n, s_at, s_len;
            logic [1:0] len;
            logic [31:0] a, d, e;
            kind = $urandom_range(0, 2);
            len = 2'($urandom_range(0, 3));
            n = (kind == 0) ? 4 : beats(len);
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                            : (32'h200 + 32'($urandom_range(0, 250)));
            d = $urandom;
            s_len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            s_at = $urandom_range(1, n);
            e = (kind == 2) ? exp_mem_rdata : model_load(a, n);
            run_txn($sformatf("rand%0d", t), kind != 0, kind == 2, len, a, d, e,
                    (kind == 2) ? n + 1 : n + 2, s_at, s_len);
        end

        // Reset during the second beat of a word store
        @(negedge clk);
        mem_req = 1; mem_we = 1; mem_len = 2'd2; mem_addr = 32'h300; mem_wdata = 32'h0102_0304;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("mid reset flags", {28'h0, busy, ram_wr, if_done, mem_done}, 32'h0);
        chk("mid reset ram_addr", ram_addr, 32'h0);
        chk("mid reset ram_dout", {24'h0, ram_dout}, 32'h0);
        chk("mid reset if_data", if_data, 32'h0);
        chk("mid reset mem_rdata", mem_rdata, 32'h0);
        mem_req = 0;
        exp_if_data = 32'h0; exp_mem_rdata = 32'h0;
        @(negedge clk); rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (mem_done) seen = 1;
        end
        chk("no mem_done after reset", {31'h0, seen}, 32'h0);
        run_txn("after reset", 0, 0, 2'd0, 32'h100, 32'h0, 32'h0000_0513, 6, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
